// File: rtl/conv2d_line_buffer.sv
// Streaming KxK window generator for raster-order pixels: K-1 line buffers
// feed a KxK shift-register window, with a one-deep stall on win_ack.
module conv2d_line_buffer #(
   parameter int DATA_W = 8,
   parameter int IMG_W  = 8,
   parameter int IMG_H  = 8,
   parameter int K      = 3
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [DATA_W-1:0]          pix_in,
   input  logic                       pix_valid,
   output logic                       pix_ready,
   input  logic                       win_ack,
   output logic                       win_valid,
   output logic [K*K*DATA_W-1:0]      win_data,
   output logic                       frame_done,
   output logic                       state_dbg
);

   localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

   localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
   localparam logic [CW-1:0] COL_WIN  = CW'(K - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
   localparam logic [RW-1:0] ROW_FILL = RW'(K - 2);

   typedef enum logic {FILL = 1'b0, RUN = 1'b1} state_t;

   state_t            state, state_nxt;
   logic              run;
   logic [CW-1:0]     col;
   logic [RW-1:0]     row;
   logic              accept;
   logic              last_pix;
   logic              row_end;

   logic [DATA_W-1:0] line_buf [K-1][IMG_W];
   logic [DATA_W-1:0] win      [K][K];

   // Handshake: a pixel moves on any edge where pix_valid && pix_ready.
   // pix_ready is high whenever the output window slot is empty or being
   // consumed this cycle, so a stalled window is never overwritten.
   assign pix_ready = !win_valid || win_ack;
   assign accept    = pix_valid && pix_ready;
   assign row_end   = (col == COL_LAST);
   assign last_pix  = row_end && (row == ROW_LAST);

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= FILL;
      end else begin
         state <= state_nxt;
      end
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_nxt = state;
      case (state)
         FILL: if (accept && row_end && (row == ROW_FILL)) state_nxt = RUN;
         RUN:  if (accept && last_pix)                    state_nxt = FILL;
         default:                                         state_nxt = FILL;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      run       = 1'b0;
      state_dbg = 1'b0;
      case (state)
         FILL: begin
            run       = 1'b0;
            state_dbg = 1'b0;
         end
         RUN: begin
            run       = 1'b1;
            state_dbg = 1'b1;
         end
         default: begin
            run       = 1'b0;
            state_dbg = 1'b0;
         end
      endcase
   end

   // ---------------- position counters ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         col <= '0;
         row <= '0;
      end else if (accept) begin
         if (row_end) begin
            col <= '0;
            row <= (row == ROW_LAST) ? '0 : row + RW'(1);
         end else begin
            col <= col + CW'(1);
         end
      end
   end

   // ---------------- line buffers ----------------
   // line_buf[0] holds the most recent completed row, line_buf[K-2] the oldest.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < K-1; i++) begin
            for (int j = 0; j < IMG_W; j++) begin
               line_buf[i][j] <= '0;
            end
         end
      end else if (accept) begin
         line_buf[0][col] <= pix_in;
         for (int i = 1; i < K-1; i++) begin
            line_buf[i][col] <= line_buf[i-1][col];
         end
      end
   end

   // ---------------- KxK window ----------------
   // Row 0 is the oldest image row, column 0 the oldest image column.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K; c++) begin
               win[r][c] <= '0;
            end
         end
      end else if (accept) begin
         for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K-1; c++) begin
               win[r][c] <= win[r][c+1];
            end
         end
         for (int r = 0; r < K-1; r++) begin
            win[r][K-1] <= line_buf[K-2-r][col];
         end
         win[K-1][K-1] <= pix_in;
      end
   end

   // ---------------- output flags ----------------
   // A new pixel takes priority over a same-cycle ack; the flag then simply
   // reflects whether that pixel completes a window.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         win_valid  <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= accept && last_pix;
         if (accept) begin
            win_valid <= run && (col >= COL_WIN);
         end else if (win_ack) begin
            win_valid <= 1'b0;
         end
      end
   end

   // ---------------- flatten window ----------------
   always_comb begin
      win_data = '0;
      for (int r = 0; r < K; r++) begin
         for (int c = 0; c < K; c++) begin
            win_data[(r*K+c)*DATA_W +: DATA_W] = win[r][c];
         end
      end
   end

endmodule

// File: tb/tb_conv2d_line_buffer.sv
// Directed bench for conv2d_line_buffer (4x4 image, 3x3 kernel) with a
// window scoreboard fed by the pixel driver and drained on win_ack.
module tb_conv2d_line_buffer;

  localparam int DW = 8;
  localparam int IW = 4;
  localparam int IH = 4;
  localparam int KK = 3;
  localparam int WW = KK*KK*DW;

  logic          clk;
  logic          rst;
  logic [DW-1:0] pix_in;
  logic          pix_valid;
  logic          pix_ready;
  logic          win_ack;
  logic          win_valid;
  logic [WW-1:0] win_data;
  logic          frame_done;
  logic          state_dbg;

  conv2d_line_buffer #(
    .DATA_W(DW), .IMG_W(IW), .IMG_H(IH), .K(KK)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pix_in     (pix_in),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .win_ack    (win_ack),
    .win_valid  (win_valid),
    .win_data   (win_data),
    .frame_done (frame_done),
    .state_dbg  (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard state ----------------
  logic [WW-1:0] exp_q[$];
  int tests_run = 0;
  int failures  = 0;
  int win_cnt   = 0;
  int fd_cnt    = 0;

  localparam logic [WW-1:0] FIRST_WIN =
    {8'd10, 8'd9, 8'd8, 8'd6, 8'd5, 8'd4, 8'd2, 8'd1, 8'd0};
  localparam logic [WW-1:0] LAST_WIN =
    {8'd15, 8'd14, 8'd13, 8'd11, 8'd10, 8'd9, 8'd7, 8'd6, 8'd5};

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    tests_run++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic check_win(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    tests_run++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [DW-1:0] pix_val(input int base, input int r, input int c);
    return DW'(base + r*IW + c);
  endfunction

  function automatic logic [WW-1:0] exp_win(input int base, input int r, input int c);
    logic [WW-1:0] w;
    w = '0;
    for (int rr = 0; rr < KK; rr++) begin
      for (int cc = 0; cc < KK; cc++) begin
        w[(rr*KK+cc)*DW +: DW] = pix_val(base, r-(KK-1)+rr, c-(KK-1)+cc);
      end
    end
    return w;
  endfunction

  // ---------------- monitor: drain a window on every consumed cycle ----------------
  always @(negedge clk) begin
    if (!rst && win_valid && win_ack) begin
      win_cnt++;
      check_int("win_expected", exp_q.size() != 0 ? 1 : 0, 1);
      if (exp_q.size() != 0) check_win("win_data", win_data, exp_q.pop_front());
    end
    if (!rst && frame_done) fd_cnt++;
  end

  // ---------------- driver tasks ----------------
  // Holds pix_valid until the pixel is sampled with pix_ready=1, then pushes
  // the window that pixel completes (if any). Returns 1 time unit after the edge.
  task automatic send_pix(input int base, input int idx, input bit gap);
    int  r, c;
    bit  accepted;
    r = idx / IW;
    c = idx % IW;
    if (gap) begin
      pix_valid = 1'b0;
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end
    pix_in    = pix_val(base, r, c);
    pix_valid = 1'b1;
    accepted  = 1'b0;
    for (int n = 0; n < 50 && !accepted; n++) begin
      @(negedge clk);
      accepted = pix_ready;
      @(posedge clk); #1;
    end
    check_bit("accept_timeout", accepted, 1'b1);
    if (accepted && r >= KK-1 && c >= KK-1) exp_q.push_back(exp_win(base, r, c));
  endtask

  task automatic send_range(input int base, input int first, input int last, input bit gap);
    for (int i = first; i <= last; i++) send_pix(base, i, gap);
  endtask

  task automatic idle_cycle();
    pix_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  // ---------------- directed sequence ----------------
  int win_base;
  int fd_base;

  initial begin
    rst       = 1'b1;
    pix_in    = '0;
    pix_valid = 1'b0;
    win_ack   = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_bit("rst_win_valid",  win_valid,  1'b0);
    check_bit("rst_frame_done", frame_done, 1'b0);
    check_win("rst_win_data",   win_data,   '0);
    check_bit("rst_pix_ready",  pix_ready,  1'b1);
    check_bit("rst_state_fill", state_dbg,  1'b0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Frame 0: continuous stream, ack tied high
    win_ack = 1'b1;
    send_range(0, 0, 5, 1'b0);
    check_bit("fill_state_row1", state_dbg, 1'b0);
    send_range(0, 6, 7, 1'b0);
    check_bit("run_state_row2", state_dbg, 1'b1);
    send_range(0, 8, 9, 1'b0);
    check_bit("no_win_before_p10", win_valid, 1'b0);
    send_pix(0, 10, 1'b0);
    check_bit("first_win_valid", win_valid, 1'b1);
    check_win("first_win_data", win_data, FIRST_WIN);
    send_range(0, 11, 14, 1'b0);
    check_bit("no_frame_done_early", frame_done, 1'b0);
    send_pix(0, 15, 1'b0);
    check_win("last_win_data", win_data, LAST_WIN);
    check_bit("frame_done_pulse", frame_done, 1'b1);
    check_bit("state_back_fill", state_dbg, 1'b0);
    idle_cycle();
    check_bit("frame_done_one_cycle", frame_done, 1'b0);
    check_bit("ack_clears_valid", win_valid, 1'b0);
    check_int("frame0_windows", win_cnt, 4);
    check_int("frame0_frame_done", fd_cnt, 1);

    // Frame 1 with a 5-cycle stall on the first window, then frame 2 back to back
    win_base = win_cnt;
    fd_base  = fd_cnt;
    send_range(16, 0, 10, 1'b0);
    win_ack   = 1'b0;
    pix_in    = pix_val(16, 2, 3);
    pix_valid = 1'b1;
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      check_bit("stall_pix_ready", pix_ready, 1'b0);
      check_bit("stall_win_valid", win_valid, 1'b1);
      check_win("stall_win_data", win_data, exp_win(16, 2, 2));
      @(posedge clk); #1;
    end
    win_ack = 1'b1;
    @(negedge clk);
    check_bit("ack_pix_ready", pix_ready, 1'b1);
    @(posedge clk); #1;
    exp_q.push_back(exp_win(16, 2, 3));
    check_bit("ack_same_cycle_valid", win_valid, 1'b1);
    check_win("ack_same_cycle_data", win_data, exp_win(16, 2, 3));
    send_range(16, 12, 15, 1'b0);
    send_range(32, 0, 15, 1'b1);
    idle_cycle();
    check_int("two_frames_windows", win_cnt - win_base, 8);
    check_int("two_frames_frame_done", fd_cnt - fd_base, 2);
    check_int("queue_drained_b2b", exp_q.size(), 0);

    // Reset in the middle of a frame, then a fresh frame
    send_range(48, 0, 6, 1'b0);
    pix_valid = 1'b0;
    win_ack   = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check_bit("midrst_win_valid",  win_valid,  1'b0);
    check_bit("midrst_frame_done", frame_done, 1'b0);
    check_win("midrst_win_data",   win_data,   '0);
    check_bit("midrst_pix_ready",  pix_ready,  1'b1);
    check_bit("midrst_state_fill", state_dbg,  1'b0);
    rst     = 1'b0;
    win_ack = 1'b1;
    @(posedge clk); #1;
    win_base = win_cnt;
    send_range(0, 0, 9, 1'b0);
    check_bit("restart_no_early_win", win_valid, 1'b0);
    send_pix(0, 10, 1'b0);
    check_win("restart_first_win", win_data, FIRST_WIN);
    send_range(0, 11, 15, 1'b0);
    idle_cycle();
    idle_cycle();
    check_int("restart_windows", win_cnt - win_base, 4);
    check_int("queue_drained_end", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule
